// File: rtl/bootram_loader_pkg.sv
// Shared constants and state encoding for the boot RAM loader.
package bootram_loader_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         LANES         = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    function automatic logic in_frame(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/bootram_loader.sv
// Frame receiver that writes payload bytes into four byte-lane boot RAMs
// and holds the CPU in reset until a checksum-verified frame has landed.
//
// state | meaning
// IDLE  | hunting for MAGIC, other bytes dropped
// LEN0  | expecting length low byte
// LEN1  | expecting length high byte, range check
// DATA  | payload bytes, one lane write per byte
// CSUM  | expecting checksum byte
// DONE  | image loaded, CPU released, waits for reload
// ERR   | one-cycle error state, back to IDLE
module bootram_loader
    import bootram_loader_pkg::*;
#(
    parameter int         ADDR_W      = 11,
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
    parameter int         TIMEOUT_CYC = 27000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic              reload,
    output logic              ram_ce,
    output logic [LANES-1:0]  ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [7:0]        ram_din,
    output logic              cpu_resetn,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int              CNT_W   = ADDR_W + 2;
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     LEN_MAX = 16'(1 << ADDR_W);

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [LANES-1:0]    wre_q, wre_d;
    logic [ADDR_W-1:0]   ad_q, ad_d;
    logic [7:0]          din_q, din_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                cpu_rstn_q, cpu_rstn_d;

    logic                accept;
    logic [15:0]         len_full;
    logic [CNT_W-1:0]    last_idx;

    assign s_ready  = (state_q != ST_DONE) && (state_q != ST_ERR);
    assign accept   = s_valid && s_ready;
    assign len_full = {s_data, len_lo_q};

    // LEN == 2**ADDR_W stores as 0 here; 0 - 1 wraps to the last byte index.
    assign last_idx = {len_q, 2'b00} - CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        to_d       = '0;
        wre_d      = '0;
        ad_d       = ad_q;
        din_d      = din_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && (s_data == MAGIC)) begin
                    state_d = ST_LEN0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            ST_LEN0: begin
                if (accept) begin
                    len_lo_d = s_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (accept) begin
                    len_d = len_full[ADDR_W-1:0];
                    if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else if (len_full > LEN_MAX) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d   = '0;
                        csum_d  = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wre_d  = LANES'(1) << cnt_q[1:0];
                    ad_d   = cnt_q[CNT_W-1:2];
                    din_d  = s_data;
                    cnt_d  = cnt_q + CNT_W'(1);
                    csum_d = csum_q + s_data;
                    if (cnt_q == last_idx) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: begin
                if (reload) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte arriving in the terminal cycle wins over the timeout.
        if (in_frame(state_q) && !accept) begin
            if (to_q == TO_LAST) begin
                state_d = ST_ERR;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end

        if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
            err_d = 1'b1;
        end

        done_d     = (state_d == ST_DONE);
        cpu_rstn_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            to_q       <= '0;
            wre_q      <= '0;
            ad_q       <= '0;
            din_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cpu_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            to_q       <= to_d;
            wre_q      <= wre_d;
            ad_q       <= ad_d;
            din_q      <= din_d;
            err_q      <= err_d;
            done_q     <= done_d;
            cpu_rstn_q <= cpu_rstn_d;
        end
    end

    assign ram_wre    = wre_q;
    assign ram_ce     = |wre_q;
    assign ram_ad     = ad_q;
    assign ram_din    = din_q;
    assign busy       = in_frame(state_q);
    assign done       = done_q;
    assign err        = err_q;
    assign cpu_resetn = cpu_rstn_q;

endmodule

// File: doc/bootram_loader.md
Name: bootram_loader

Overview:
- Writer side of the 2Kx8 boot RAM lanes. Receives a framed byte stream (UART RX or debug bridge) over valid/ready.
- Writes each payload byte into the matching byte lane (lane = byte index mod 4, address = word index).
- Holds the PicoRV32 in reset until a frame with a good checksum has been written.
- Sits between the byte source and the four single-port 2Kx8 lane RAMs' write port; owns ce/wre/ad/din while loading.

Parameters:
- ADDR_W, 11, word address width; capacity 2**ADDR_W words.
- MAGIC, 8'hA5, frame start byte.
- TIMEOUT_CYC, 27000000, max idle cycles between bytes inside a frame (1 s at 27 MHz).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- s_valid  in  1  byte available
- s_data  in  8  byte value
- s_ready  out  1  loader accepts byte this cycle
- reload  in  1  single-cycle pulse; from DONE, re-arms loading and re-asserts CPU reset
- ram_ce  out  1  lane RAM clock enable (all lanes)
- ram_wre  out  4  per-lane write enable, one-hot, bit n = lane n
- ram_ad  out  ADDR_W  word address
- ram_din  out  8  write data (shared by all lanes)
- cpu_resetn  out  1  low until load succeeds
- busy  out  1  frame in progress (LEN0..CSUM)
- done  out  1  last frame loaded OK
- err  out  1  sticky error flag, cleared on next MAGIC

Behaviour:
- Frame format: MAGIC, LEN_LO, LEN_HI (LEN in 32-bit words), then 4*LEN payload bytes little-endian (byte0 to lane0), then CSUM = 8-bit sum of payload bytes mod 256.
- Byte acceptance occurs on s_valid & s_ready.
- s_ready is 1 in IDLE, LEN0, LEN1, DATA and CSUM; it is 0 in DONE and ERR.
- States and transitions:
  - IDLE: an accepted byte equal to MAGIC goes to LEN0 and clears err. Any other byte is dropped and the state stays IDLE.
  - LEN0: store LEN[7:0], go to LEN1.
  - LEN1: store LEN[15:8].
    - LEN == 0 goes to CSUM.
    - LEN > 2**ADDR_W goes to ERR.
    - Otherwise clear the byte counter and checksum, then go to DATA.
  - DATA: each accepted byte registers a write on the next cycle.
    - ram_ce=1; ram_wre = 1<<cnt[1:0]; ram_ad = cnt[ADDR_W+1:2]; ram_din = byte.
    - cnt increments and the checksum accumulates.
    - After byte 4*LEN-1, go to CSUM.
  - CSUM: if the accepted byte equals the checksum go to DONE, else go to ERR.
  - DONE: cpu_resetn=1, done=1. reload goes to IDLE with cpu_resetn=0 and done=0.
  - ERR: set err=1, go to IDLE after 1 cycle. cpu_resetn stays 0.
- Write latency: exactly 1 cycle from acceptance to the wre pulse. wre is high for exactly 1 cycle per byte; ram_ce equals |ram_wre.
- Outside writes, ram_wre=0 and ram_ce=0. ram_ad and ram_din hold their last values.
- Timeout:
  - Counter is cleared on every accepted byte and on entry to LEN0.
  - It counts in LEN0, LEN1, DATA and CSUM while no byte is accepted.
  - Reaching TIMEOUT_CYC-1 goes to ERR.
  - In IDLE, DONE and ERR the counter is held at 0.
- MAGIC inside a frame is ordinary data; there is no resync mid-frame.
- reload is ignored in all states except DONE.
- Counter and checksum widths:
  - cnt is ADDR_W+2 bits.
  - LEN compare uses 16 bits; the 4*LEN compare is done in ADDR_W+2 bits after the range check.
  - Checksum is 8 bits and wraps.
- Reset (resetn=0 at a clk edge), including mid-frame:
  - state=IDLE.
  - cpu_resetn=0, done=0, err=0, busy=0.
  - ram_wre=0, ram_ce=0, ram_ad=0, ram_din=0.
  - Counters = 0.
  - Partially written RAM content is left as-is.
- Simultaneous events: a byte accepted in the timeout cycle is processed normally and the timeout does not fire.

Decomposition:
- Package bootram_loader_pkg holds:
  - State enum: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - Default MAGIC constant.
  - Lane count constant (4).
- No sub-module; the timeout counter and checksum are inline. The top-level instantiates this block alongside the four lane RAMs and muxes the RAM address with the CPU fetch path using cpu_resetn.

Test Plan:
- Reset then frame A5 01 00 11 22 33 44 AA → wre 0001/0010/0100/1000 at ad=0 with din 11/22/33/44; checksum 0xAA matches; done=1, cpu_resetn=1.
- Same frame with CSUM 0xAB → err=1, done=0, cpu_resetn=0, state back to IDLE; a following good frame clears err and gives done=1.
- Frame LEN=0x0801 (2049 > 2048) → err after LEN_HI, no wre pulses; LEN=0x0800 with 8192 bytes → last write at ad=0x7FF, wre=1000.
- Frame stalled after 2 payload bytes for TIMEOUT_CYC cycles (TIMEOUT_CYC=16 in sim) → err=1 at cycle 16, no further writes; stall of 15 cycles then resume → completes OK.
- Bytes 00 FF before A5 → dropped, no writes; reload in DONE → cpu_resetn=0 next cycle, new frame loads; reload while in DATA → ignored.
- resetn low mid-DATA → all outputs at reset values the next cycle; the next frame writes from ad=0, lane 0.
